// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: forward-select encodings, stage indices, operand mux.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package pipe_pkg;

    // Width of the PC tag carried by every pipeline register
    localparam int TAG_W      = 32;
    localparam int NUM_STAGES = 4;

    // Stage indices into the per-register control/valid vectors
    localparam int STG_IFID  = 3;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 1;
    localparam int STG_MEMWB = 0;

    // Operand source selects coming from the forwarding unit
    typedef enum logic [1:0] {
        FWD_RF        = 2'b00,
        FWD_MEMWB_LD  = 2'b01,
        FWD_EXMEM_ALU = 2'b10,
        FWD_MEMWB_ALU = 2'b11
    } fwd_sel_e;

    // Pick one ALU operand from the register file or a bypass path
    function automatic logic [TAG_W-1:0] fwd_mux(
        input fwd_sel_e         sel,
        input logic [TAG_W-1:0] rf_dat,
        input logic [TAG_W-1:0] exmem_alu_dat,
        input logic [TAG_W-1:0] memwb_ld_dat,
        input logic [TAG_W-1:0] memwb_alu_dat
    );
        logic [TAG_W-1:0] res;
        res = rf_dat;
        case (sel)
            FWD_RF:        res = rf_dat;
            FWD_EXMEM_ALU: res = exmem_alu_dat;
            FWD_MEMWB_LD:  res = memwb_ld_dat;
            FWD_MEMWB_ALU: res = memwb_alu_dat;
            default:       res = rf_dat;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline register: PC tag plus valid bit, loaded from its upstream stage.
// Latency: 1 cycle (registered on rising clk).
// Backpressure: wen_i=0 holds the entry; flush_i clears valid with priority, tag still follows wen_i.
module pipe_stage_reg
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wen_i,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] up_tag_i,
    input  logic             up_vld_i,
    output logic [TAG_W-1:0] tag_o,
    output logic             vld_o
);

    logic [TAG_W-1:0] tag_q, tag_d;
    logic             vld_q, vld_d;

    // Next state: advance on write enable, flush only kills the valid bit so the
    // tag of a squashed slot keeps moving with it as a bubble
    always_comb begin
        tag_d = tag_q;
        vld_d = vld_q;
        if (wen_i) begin
            tag_d = up_tag_i;
            vld_d = up_vld_i;
        end
        if (flush_i) begin
            vld_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously so in-flight entries vanish at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
            vld_q <= 1'b0;
        end else begin
            tag_q <= tag_d;
            vld_q <= vld_d;
        end
    end

    assign tag_o = tag_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Pipeline control slice: PC register, four PC-tag/valid stage registers, operand forwarding
// muxes and (with PIPE_PERF_CNT_EN defined) saturating stall/flush counters.
// Latency: 1 cycle per stage, PC to MEM/WB in 4 edges; op_a/op_b are combinational.
// Backpressure: pcen holds the PC, mid_reg_write holds individual stages, stall bubbles them.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_next,
    input  logic             pcen,
    input  logic [3:0]       mid_reg_write,
    input  logic [3:0]       stall,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic [31:0]      exmem_alu,
    input  logic [31:0]      memwb_alu,
    input  logic [31:0]      memwb_load,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      idex_pc,
    output logic [31:0]      exmem_pc,
    output logic [31:0]      memwb_pc,
    output logic [3:0]       valid,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             retire
);

    // Counters of width 0 or wider than 32 make no sense for this block
    if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_w_chk
        $error("pipe_stage_ctrl: CNT_W must be in 1..32");
    end

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    logic [31:0] pc_q, pc_d;

    // Load the fetch/branch target when the hazard unit allows, else hold
    always_comb begin
        pc_d = pc_q;
        if (pcen) begin
            pc_d = pc_next;
        end
    end

    // PC register, reset to the boot vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] stg_tag [NUM_STAGES];
    logic             stg_vld [NUM_STAGES];
    logic [TAG_W-1:0] up_tag  [NUM_STAGES];
    logic             up_vld  [NUM_STAGES];

    // Upstream of IF/ID is the current PC as a fresh valid fetch; every other
    // register takes the pre-edge contents of the stage in front of it
    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            up_tag[i] = '0;
            up_vld[i] = 1'b0;
        end
        up_tag[STG_IFID] = pc_q;
        up_vld[STG_IFID] = 1'b1;
        for (int i = 0; i < STG_IFID; i++) begin
            up_tag[i] = stg_tag[i+1];
            up_vld[i] = stg_vld[i+1];
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        pipe_stage_reg u_stage_reg (
            .clk      (clk),
            .rst      (rst),
            .wen_i    (mid_reg_write[g]),
            .flush_i  (stall[g]),
            .up_tag_i (up_tag[g]),
            .up_vld_i (up_vld[g]),
            .tag_o    (stg_tag[g]),
            .vld_o    (stg_vld[g])
        );
    end

    assign ifid_pc  = stg_tag[STG_IFID];
    assign idex_pc  = stg_tag[STG_IDEX];
    assign exmem_pc = stg_tag[STG_EXMEM];
    assign memwb_pc = stg_tag[STG_MEMWB];
    assign valid    = {stg_vld[STG_IFID], stg_vld[STG_IDEX],
                       stg_vld[STG_EXMEM], stg_vld[STG_MEMWB]};
    assign retire   = stg_vld[STG_MEMWB];

    // ------------------------------------------------------------------
    // Operand forwarding (purely combinational, independent of reset)
    // ------------------------------------------------------------------
    assign op_a = fwd_mux(fwd_sel_e'(forward_a), rs_data, exmem_alu, memwb_load, memwb_alu);
    assign op_b = fwd_mux(fwd_sel_e'(forward_b), rt_data, exmem_alu, memwb_load, memwb_alu);

`ifdef PIPE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Count PC-hold cycles and cycles with any flush; stick at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pcen && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((stall != 4'b0000) && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: reset, free run, load-use bubble, branch flush,
// forwarding table, mid-operation reset and (with PIPE_PERF_CNT_EN) counter saturation.
// Inputs change 1 time unit after a rising edge; outputs are compared at that point.
module tb_pipe_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_next;
    logic        pcen;
    logic [3:0]  mid_reg_write;
    logic [3:0]  stall;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] rs_data, rt_data, exmem_alu, memwb_alu, memwb_load;
    logic [31:0] op_a, op_b;
    logic [31:0] pc, ifid_pc, idex_pc, exmem_pc, memwb_pc;
    logic [3:0]  valid;
    logic        retire;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]  stall_cnt, flush_cnt;
`endif

    // Fetch logic stand-in: sequential PC unless a branch target is forced
    logic        br_en;
    logic [31:0] br_tgt;
    assign pc_next = br_en ? br_tgt : pc + 32'd4;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(
        .RESET_PC (32'h0000_3000)
`ifdef PIPE_PERF_CNT_EN
        , .CNT_W  (4)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_next       (pc_next),
        .pcen          (pcen),
        .mid_reg_write (mid_reg_write),
        .stall         (stall),
        .forward_a     (forward_a),
        .forward_b     (forward_b),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .exmem_alu     (exmem_alu),
        .memwb_alu     (memwb_alu),
        .memwb_load    (memwb_load),
        .op_a          (op_a),
        .op_b          (op_b),
        .pc            (pc),
        .ifid_pc       (ifid_pc),
        .idex_pc       (idex_pc),
        .exmem_pc      (exmem_pc),
        .memwb_pc      (memwb_pc),
        .valid         (valid),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .retire        (retire)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } fwd_vec_t;

    fwd_vec_t vecs [8];

    initial begin
        // Forwarding vectors: exmem_alu=2, memwb_load=3, memwb_alu=4 throughout
        vecs[0] = '{2'b00, 2'b11, 32'd1,  32'd1,  32'd1,  32'd4};
        vecs[1] = '{2'b10, 2'b01, 32'd1,  32'd1,  32'd2,  32'd3};
        vecs[2] = '{2'b01, 2'b10, 32'd1,  32'd1,  32'd3,  32'd2};
        vecs[3] = '{2'b11, 2'b00, 32'd1,  32'd1,  32'd4,  32'd1};
        vecs[4] = '{2'b00, 2'b00, 32'hA,  32'hB,  32'hA,  32'hB};
        vecs[5] = '{2'b11, 2'b11, 32'hA,  32'hB,  32'd4,  32'd4};
        vecs[6] = '{2'b10, 2'b10, 32'hA,  32'hB,  32'd2,  32'd2};
        vecs[7] = '{2'b01, 2'b00, 32'hA,  32'hB,  32'd3,  32'hB};

        rst           = 1'b1;
        pcen          = 1'b0;
        mid_reg_write = 4'b0000;
        stall         = 4'b0000;
        forward_a     = 2'b00;
        forward_b     = 2'b00;
        rs_data       = 32'd1;
        rt_data       = 32'd1;
        exmem_alu     = 32'd2;
        memwb_load    = 32'd3;
        memwb_alu     = 32'd4;
        br_en         = 1'b0;
        br_tgt        = 32'h0000_4000;

        // Reset state
        #8;
        chk("rst_pc",       pc,           32'h0000_3000);
        chk("rst_ifid_pc",  ifid_pc,      32'h0);
        chk("rst_idex_pc",  idex_pc,      32'h0);
        chk("rst_exmem_pc", exmem_pc,     32'h0);
        chk("rst_memwb_pc", memwb_pc,     32'h0);
        chk("rst_valid",    32'(valid),   32'h0);
        chk("rst_retire",   32'(retire),  32'h0);

        // Forwarding table
        for (int i = 0; i < 8; i++) begin
            forward_a = vecs[i].fa;
            forward_b = vecs[i].fb;
            rs_data   = vecs[i].rs;
            rt_data   = vecs[i].rt;
            #1;
            chk($sformatf("fwd_op_a[%0d]", i), op_a, vecs[i].exp_a);
            chk($sformatf("fwd_op_b[%0d]", i), op_b, vecs[i].exp_b);
        end

        // Free run from reset
        #2;
        rst           = 1'b0;
        pcen          = 1'b1;
        mid_reg_write = 4'b1111;
        stall         = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("run_pc[%0d]", k),      pc,      32'h3000 + 32'(4 * k));
            chk($sformatf("run_ifid_pc[%0d]", k), ifid_pc, 32'h3000 + 32'(4 * (k - 1)));
            chk($sformatf("run_memwb_pc[%0d]", k), memwb_pc,
                (k >= 4) ? 32'h3000 + 32'(4 * (k - 4)) : 32'h0);
            chk($sformatf("run_valid[%0d]", k), 32'(valid),
                32'({k >= 1, k >= 2, k >= 3, k >= 4}));
            chk($sformatf("run_retire[%0d]", k), 32'(retire), 32'(k >= 4));
        end

        // Load-use: IF/ID and PC hold, ID/EX takes a bubble, EX/MEM and MEM/WB advance
        pcen          = 1'b0;
        mid_reg_write = 4'b0111;
        stall         = 4'b0100;
        tick();
        chk("lu_pc",       pc,         32'h0000_3020);
        chk("lu_ifid_pc",  ifid_pc,    32'h0000_301C);
        chk("lu_idex_pc",  idex_pc,    32'h0000_301C);
        chk("lu_exmem_pc", exmem_pc,   32'h0000_3018);
        chk("lu_memwb_pc", memwb_pc,   32'h0000_3014);
        chk("lu_valid",    32'(valid), 32'b1011);
        pcen          = 1'b1;
        mid_reg_write = 4'b1111;
        stall         = 4'b0000;
        tick();
        chk("lu_valid_p1", 32'(valid),  32'b1101);
        chk("lu_idex_p1",  idex_pc,     32'h0000_301C);
        tick();
        chk("lu_valid_p2",  32'(valid),  32'b1110);
        chk("lu_retire_p2", 32'(retire), 32'h0);
        chk("lu_memwb_p2",  memwb_pc,    32'h0000_301C);
        tick();
        chk("lu_valid_p3", 32'(valid), 32'b1111);
        chk("lu_pc_p3",    pc,         32'h0000_302C);

        // Branch flush: squash ID/EX and EX/MEM, redirect PC
        br_en = 1'b1;
        stall = 4'b0110;
        tick();
        br_en = 1'b0;
        stall = 4'b0000;
        chk("br_pc",     pc,          32'h0000_4000);
        chk("br_valid",  32'(valid),  32'b1001);
        chk("br_retire", 32'(retire), 32'h1);
        tick();
        chk("br_pc_p1",     pc,          32'h0000_4004);
        chk("br_valid_p1",  32'(valid),  32'b1100);
        chk("br_retire_p1", 32'(retire), 32'h0);
        tick();
        chk("br_retire_p2", 32'(retire), 32'h0);
        tick();
        chk("br_retire_p3", 32'(retire), 32'h1);
        chk("br_valid_p3",  32'(valid),  32'b1111);

        // Mid-operation reset between edges with a full pipe
        #3;
        rst       = 1'b1;
        forward_a = 2'b10;
        forward_b = 2'b01;
        #1;
        chk("mr_valid",    32'(valid), 32'h0);
        chk("mr_pc",       pc,         32'h0000_3000);
        chk("mr_memwb_pc", memwb_pc,   32'h0);
        chk("mr_op_a",     op_a,       32'd2);
        chk("mr_op_b",     op_b,       32'd3);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("mr_retire[%0d]", k), 32'(retire), 32'(k >= 4));
        end
        chk("mr_memwb_pc_4", memwb_pc, 32'h0000_3000);

`ifdef PIPE_PERF_CNT_EN
        // Counter saturation with CNT_W=4
        pcen          = 1'b0;
        mid_reg_write = 4'b0000;
        stall         = 4'b0000;
        repeat (10) tick();
        chk("cnt_stall_10", 32'(stall_cnt), 32'd10);
        chk("cnt_flush_0",  32'(flush_cnt), 32'd0);
        repeat (10) tick();
        chk("cnt_stall_20", 32'(stall_cnt), 32'd15);
        chk("cnt_pc_held",  pc,             32'h0000_3010);
        stall = 4'b0001;
        repeat (3) tick();
        stall = 4'b0000;
        chk("cnt_flush_3",  32'(flush_cnt), 32'd3);
        chk("cnt_stall_hold", 32'(stall_cnt), 32'd15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
